// File: rtl/fpu_pkg.sv
// Shared FPU front-end definitions: loader state encoding, opcode
// constants and the half-precision / unpacked operand field widths.
package fpu_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int UNPK_W = 18;

    localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        LOAD_OP   = 3'd2,
        LAUNCH    = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/half_unpack.sv
// Half-precision word unpacker: {sign, exp, 1'b0, hidden, frac}.
// Ports: word_i (16b IEEE half), unpk_o (18b unpacked operand).
// Macro OPERAND_LOADER_FTZ_EN: flush subnormal inputs to signed zero.
module half_unpack
    import fpu_pkg::*;
(
    input  logic [15:0]       word_i,
    output logic [UNPK_W-1:0] unpk_o
);

    logic              sign;
    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac;
    logic              hidden;

    assign sign   = word_i[15];
    assign exp_f  = word_i[14:10];
    assign frac   = word_i[9:0];
    assign hidden = (exp_f != '0);

`ifdef OPERAND_LOADER_FTZ_EN
    // exp==0 with frac!=0 is subnormal; flush keeps the sign only
    assign unpk_o = (!hidden && frac != '0) ? {sign, 17'b0}
                                            : {sign, exp_f, 1'b0, hidden, frac};
`else
    assign unpk_o = {sign, exp_f, 1'b0, hidden, frac};
`endif

endmodule

// File: rtl/operand_loader.sv
// Loads operand A, operand B and an opcode from a valid/ready stream,
// then fires 4 start pulses (each followed by PULSE_GAP idle cycles)
// and waits for done before accepting the next transaction.
// Ports: clk, rst (async high), in_valid/in_data/in_ready (stream in),
//        done (FPU ready/error), A/B (18b unpacked), O (opcode),
//        start (step pulse), busy, nan_flag (A or B exp==31).
// Macro OPERAND_LOADER_FTZ_EN: flush subnormals (see half_unpack).
module operand_loader
    import fpu_pkg::*;
#(
    parameter int PULSE_GAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              in_ready,
    input  logic              done,
    output logic [UNPK_W-1:0] A,
    output logic [UNPK_W-1:0] B,
    output logic [1:0]        O,
    output logic              start,
    output logic              busy,
    output logic              nan_flag
);

    localparam logic [2:0] GAP = 3'(PULSE_GAP);

    state_t            state_q, state_d;
    logic [UNPK_W-1:0] a_q, a_d;
    logic [UNPK_W-1:0] b_q, b_d;
    logic [1:0]        o_q, o_d;
    logic              nan_q, nan_d;
    logic [1:0]        pulse_q, pulse_d;
    logic [2:0]        phase_q, phase_d;
    logic [UNPK_W-1:0] unpk;

    half_unpack u_unpack (
        .word_i (in_data),
        .unpk_o (unpk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            o_q     <= '0;
            nan_q   <= 1'b0;
            pulse_q <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            o_q     <= o_d;
            nan_q   <= nan_d;
            pulse_q <= pulse_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        o_d      = o_q;
        nan_d    = nan_q;
        pulse_d  = pulse_q;
        phase_d  = phase_q;
        in_ready = 1'b0;
        start    = 1'b0;
        unique case (state_q)
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = unpk;
                    nan_d   = 1'b0;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    b_d     = unpk;
                    // A exponent sits at unpacked bits [16:12]
                    nan_d   = (a_q[UNPK_W-2 -: EXP_W] == EXP_MAX) ||
                              (in_data[14:10] == EXP_MAX);
                    state_d = LOAD_OP;
                end
            end
            LOAD_OP: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    o_d     = in_data[1:0];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                // phase 0 is the pulse, phases 1..GAP are idle
                start = (phase_q == '0);
                if (phase_q == GAP) begin
                    phase_d = '0;
                    if (pulse_q == 2'd3) begin
                        pulse_d = '0;
                        state_d = WAIT_DONE;
                    end else begin
                        pulse_d = pulse_q + 2'd1;
                    end
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            WAIT_DONE: begin
                if (done) state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    assign A        = a_q;
    assign B        = b_q;
    assign O        = o_q;
    assign nan_flag = nan_q;
    assign busy     = (state_q != LOAD_A);

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader (PULSE_GAP=1).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_operand_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        done;
    logic [17:0] A;
    logic [17:0] B;
    logic [1:0]  O;
    logic        start;
    logic        busy;
    logic        nan_flag;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    operand_loader #(.PULSE_GAP(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .done     (done),
        .A        (A),
        .B        (B),
        .O        (O),
        .start    (start),
        .busy     (busy),
        .nan_flag (nan_flag)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    // 8 LAUNCH cycles: pulses on cycles 0,2,4,6
    task automatic launch_chk(input string tag);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_start"}, 32'(start), 32'((i % 2) == 0));
            check({tag, "_rdy"}, 32'(in_ready), 32'd0);
            tick();
        end
    endtask

    task automatic finish_txn();
        check("wait_start", 32'(start), 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rdy", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        done     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_A", 32'(A), 32'd0);
        check("rst_B", 32'(B), 32'd0);
        check("rst_O", 32'(O), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_nan", 32'(nan_flag), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_rdy", 32'(in_ready), 32'd1);

        // basic load: 1.0, 2.0, mul
        send(16'h3C00);
        check("t1_A", 32'(A), 32'h0F400);
        check("t1_busy_b", 32'(busy), 32'd1);
        send(16'h4000);
        check("t1_B", 32'(B), 32'h10400);
        send(16'h0002);
        check("t1_O", 32'(O), 32'd2);
        check("t1_busy", 32'(busy), 32'd1);
        // hold valid high through LAUNCH/WAIT_DONE
        in_valid = 1'b1;
        in_data  = 16'h1234;
        launch_chk("t1");
        for (int i = 0; i < 3; i++) begin
            check("t2_wait_rdy", 32'(in_ready), 32'd0);
            check("t2_wait_start", 32'(start), 32'd0);
            tick();
        end
        check("t2_A_hold", 32'(A), 32'h0F400);
        check("t2_B_hold", 32'(B), 32'h10400);
        check("t2_O_hold", 32'(O), 32'd2);
        finish_txn();
        check("t2_A_idle", 32'(A), 32'h0F400);
        tick();
        in_valid = 1'b0;
        check("t2_A_new", 32'(A), 32'h04634);
        check("t2_state_b", 32'(busy), 32'd1);

        // done during LOAD_B is ignored
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_rdy", 32'(in_ready), 32'd1);
        check("t5_A_keep", 32'(A), 32'h04634);
        send(16'h3C00);
        check("t5_B", 32'(B), 32'h0F400);
        send(16'hFFFF);
        check("t5_O", 32'(O), 32'd3);
        launch_chk("t5");
        finish_txn();

        // NaN flag
        send(16'h7E00);
        check("t4_A", 32'(A), 32'h1F600);
        check("t4_nan_pre", 32'(nan_flag), 32'd0);
        send(16'h3C00);
        check("t4_nan_set", 32'(nan_flag), 32'd1);
        send(16'h0000);
        check("t4_O", 32'(O), 32'd0);
        launch_chk("t4");
        finish_txn();
        check("t4_nan_hold", 32'(nan_flag), 32'd1);

        // subnormal A; also clears nan_flag
        send(16'h0001);
        check("t4_nan_clr", 32'(nan_flag), 32'd0);
`ifdef OPERAND_LOADER_FTZ_EN
        check("t3_sub_A", 32'(A), 32'h00000);
`else
        check("t3_sub_A", 32'(A), 32'h00001);
`endif

        // reset mid-LAUNCH after second pulse
        send(16'h4000);
        send(16'h0001);
        check("t6_p0", 32'(start), 32'd1);
        tick();
        tick();
        check("t6_p1", 32'(start), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("t6_start", 32'(start), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_A", 32'(A), 32'd0);
        check("t6_B", 32'(B), 32'd0);
        check("t6_O", 32'(O), 32'd0);
        check("t6_nan", 32'(nan_flag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t6_no_pulse", 32'(start), 32'd0);
            check("t6_idle", 32'(busy), 32'd0);
        end
        check("t6_rdy", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
